// File: rtl/apb_regfile_bridge.sv
`timescale 1ns/1ps
// apb_regfile_bridge: APB slave that converts APB transfers into single-word
// register-file cycles, with address decode, read wait-state handling,
// read timeout and a saturating error counter.
//
// Ports:
//   clk, rst_n           sole clock, synchronous active-low reset
//   psel, penable,       APB request (setup/access phases)
//   pwrite, paddr, pwdata
//   prdata, pready,      APB response (registered)
//   pslverr
//   addr, chip_select,   register-file request (registered)
//   write_en, read_en,
//   write_data
//   read_data,           register-file read return
//   data_valid
//   err_count            saturating count of error responses
module apb_regfile_bridge #(
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] ADDR_MAX   = ADDR_WIDTH'(8'h1C),
    parameter int unsigned           TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  chip_select,
    output logic                  write_en,
    output logic                  read_en,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic                  data_valid,
    output logic [7:0]            err_count
);

    localparam int unsigned CNT_WIDTH = 8;
    localparam logic [CNT_WIDTH-1:0] WAIT_LAST = CNT_WIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t               state;
    logic                 is_write;
    logic [CNT_WIDTH-1:0] wait_cnt;
    logic                 setup_c;
    logic                 decode_err_c;

    // Setup phase of a new APB transfer and address legality of that request
    assign setup_c      = psel && !penable;
    assign decode_err_c = (paddr[1:0] != 2'b00) || (paddr > ADDR_MAX);

    // Transfer sequencer with registered APB and register-file outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            is_write    <= 1'b0;
            wait_cnt    <= '0;
            prdata      <= '0;
            pready      <= 1'b0;
            pslverr     <= 1'b0;
            addr        <= '0;
            write_data  <= '0;
            chip_select <= 1'b0;
            write_en    <= 1'b0;
            read_en     <= 1'b0;
            err_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    pready      <= 1'b0;
                    pslverr     <= 1'b0;
                    chip_select <= 1'b0;
                    write_en    <= 1'b0;
                    read_en     <= 1'b0;
                    // Access phase without a preceding setup is ignored
                    if (setup_c) begin
                        addr       <= paddr;
                        write_data <= pwdata;
                        is_write   <= pwrite;
                        prdata     <= '0;
                        wait_cnt   <= '0;
                        if (decode_err_c) begin
                            // Illegal address: respond with an error, never touch the register file
                            state   <= RESP;
                            pready  <= 1'b1;
                            pslverr <= 1'b1;
                        end else begin
                            state       <= ISSUE;
                            chip_select <= 1'b1;
                            write_en    <= pwrite;
                            read_en     <= !pwrite;
                        end
                    end
                end

                ISSUE: begin
                    if (!psel) begin
                        // Master abandoned the transfer: end the cycle silently
                        state       <= IDLE;
                        chip_select <= 1'b0;
                        write_en    <= 1'b0;
                        read_en     <= 1'b0;
                    end else if (is_write || data_valid) begin
                        state       <= RESP;
                        pready      <= 1'b1;
                        pslverr     <= 1'b0;
                        chip_select <= 1'b0;
                        write_en    <= 1'b0;
                        read_en     <= 1'b0;
                        if (!is_write) begin
                            prdata <= read_data;
                        end
                    end else begin
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    if (!psel) begin
                        state       <= IDLE;
                        chip_select <= 1'b0;
                        read_en     <= 1'b0;
                        wait_cnt    <= '0;
                    end else if (data_valid) begin
                        // Data arriving on the last permitted cycle still wins over the timeout
                        state       <= RESP;
                        pready      <= 1'b1;
                        pslverr     <= 1'b0;
                        prdata      <= read_data;
                        chip_select <= 1'b0;
                        read_en     <= 1'b0;
                        wait_cnt    <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state       <= RESP;
                        pready      <= 1'b1;
                        pslverr     <= 1'b1;
                        prdata      <= '0;
                        chip_select <= 1'b0;
                        read_en     <= 1'b0;
                        wait_cnt    <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_WIDTH'(1);
                    end
                end

                RESP: begin
                    // One-cycle response; any setup seen here is dropped
                    state   <= IDLE;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    if (pslverr && (err_count != 8'hFF)) begin
                        err_count <= err_count + 8'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/apb_regfile_bridge.md
APB_REGFILE_BRIDGE -- requirements
Module: apb_regfile_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: width of paddr and addr.
REQ-002 Parameter DATA_WIDTH, default 32: width of all data buses.
REQ-003 Parameter ADDR_MAX, default 8'h1C: highest legal word-aligned register address.
REQ-004 Parameter TIMEOUT, default 15: maximum read-wait cycles; valid range 1-255.
REQ-005 The block SHALL use one clock; reset is synchronous and active-low. Ports:
- clk  in  1  sole clock, all state updates on posedge
- rst_n  in  1  synchronous active-low reset
- psel  in  1  APB select
- penable  in  1  APB access phase
- pwrite  in  1  APB direction, 1 = write
- paddr  in  ADDR_WIDTH  APB byte address
- pwdata  in  DATA_WIDTH  APB write data
- prdata  out  DATA_WIDTH  APB read data, registered
- pready  out  1  APB transfer complete, registered
- pslverr  out  1  APB error, valid only with pready
- addr  out  ADDR_WIDTH  register-file address, registered
- chip_select  out  1  register-file select
- write_en  out  1  register-file write strobe
- read_en  out  1  register-file read strobe
- write_data  out  DATA_WIDTH  register-file write data, registered
- read_data  in  DATA_WIDTH  register-file read data
- data_valid  in  1  register-file read data qualifier
- err_count  out  8  saturating count of error responses

Function
REQ-006 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-007 In IDLE, when psel=1 and penable=0, the block SHALL capture paddr, pwdata and pwrite on that edge and move to ISSUE.
REQ-008 In IDLE, psel=1 with penable=1 (no prior setup) SHALL be ignored; state stays IDLE and pready stays 0.
REQ-009 Decode error: captured address with addr[1:0]!=0 or addr>ADDR_MAX SHALL move IDLE->RESP directly, with pslverr=1, prdata=0 and no chip_select.
REQ-010 ISSUE, write: chip_select=1 and write_en=1 for exactly one cycle, then RESP with pslverr=0.
REQ-011 ISSUE, read: chip_select=1 and read_en=1; if data_valid=1 in that cycle, capture read_data into prdata and go to RESP; otherwise go to WAIT.
REQ-012 WAIT: chip_select and read_en held at 1; a wait counter increments each cycle.
- On data_valid=1: capture read_data and go to RESP.
- When the counter reaches TIMEOUT with no data_valid: go to RESP with pslverr=1 and prdata=0.
REQ-013 RESP: pready=1 for exactly one cycle; pslverr and prdata are held stable; next state IDLE.
REQ-014 chip_select, write_en and read_en SHALL be 0 in IDLE and RESP; write_en and read_en SHALL never be 1 together.
REQ-015 Latency, no wait states: setup edge T0, ISSUE in T1, pready=1 in T2 (three-cycle APB transfer); each extra WAIT cycle adds one.
REQ-016 Abort: if psel drops in ISSUE or WAIT, the current register-file cycle SHALL end, strobes drop the next cycle, and the FSM returns to IDLE without pready.
REQ-017 err_count SHALL increment by 1 on each RESP cycle with pslverr=1 and saturate at 8'hFF.
REQ-018 write_data and addr SHALL change only on the IDLE capture edge.
REQ-019 A new setup phase seen in the RESP cycle SHALL be ignored; back-to-back transfers start from IDLE.

Reset
REQ-020 While rst_n=0 at a posedge clk, the block SHALL reset:
- state to IDLE
- prdata, pready, pslverr, chip_select, write_en, read_en to 0
- addr, write_data, wait counter and err_count to 0
REQ-021 Reset asserted mid-transfer SHALL abort it the same edge, with no pready generated.

Verification
REQ-022 Write: setup paddr=8'h04, pwdata=32'h0000_0003, pwrite=1 -> T1 addr=8'h04, chip_select=write_en=1, write_data=32'h3; T2 pready=1, pslverr=0.
REQ-023 Read, immediate valid: paddr=8'h14, register-file read_data=32'h0000_AA55 with data_valid in T1 -> T2 pready=1, prdata=32'h0000_AA55, pslverr=0.
REQ-024 Read, delayed valid: data_valid withheld 3 cycles -> read_en held 4 cycles, pready one cycle after data_valid, prdata correct.
REQ-025 Timeout: data_valid never asserted, TIMEOUT=15 -> pready after 1+15 cycles, pslverr=1, prdata=0, err_count 0->1.
REQ-026 Decode errors: paddr=8'h05 and paddr=8'h20 -> no chip_select, pready at T1, pslverr=1, err_count +1 each; 300 errors -> err_count=8'hFF.
REQ-027 Reset mid-WAIT: rst_n=0 on the third WAIT cycle -> next edge all outputs 0, state IDLE; a following write completes normally.
